// File: rtl/alu_decoder.sv
// alu_decoder: decodes RV32I instruction words into ALU control fields and
// queues the results in a DEPTH-entry FIFO with valid/ready handshakes on
// both sides. Defining ALU_DEC_ILLEGAL_CNT_EN adds the IllegalCount port and
// a saturating counter of accepted illegal instructions.
module alu_decoder #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  ALUControl,
    output logic        ALUSrc,
    output logic [31:0] Imm,
    output logic [4:0]  Rd,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic        RegWrite,
    output logic        Illegal
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    ,
    output logic [7:0]  IllegalCount
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic [3:0]  alu;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rw;
        logic        ill;
    } dec_t;

    dec_t            mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    // Held low through reset so in_ready only rises on the first clock after release.
    logic            rdy_en_q;
    logic            push, pop;
    dec_t            dec_d, head;

    // Pure combinational RV32I subset decode; anything unrecognised is all-zero with ill set.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        d  = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        d.ill = 1'b1;
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000000 && f3 == 3'b000) begin d.ill = 1'b0; d.alu = ALU_ADD; end
                else if (f7 == 7'b0100000 && f3 == 3'b000) begin d.ill = 1'b0; d.alu = ALU_SUB; end
                else if (f7 == 7'b0000000 && f3 == 3'b110) begin d.ill = 1'b0; d.alu = ALU_OR; end
                else if (f7 == 7'b0000000 && f3 == 3'b111) begin d.ill = 1'b0; d.alu = ALU_AND; end
                d.rw = 1'b1;
                d.rd = ins[11:7];
            end
            7'b0010011: begin
                if (f3 == 3'b000) begin d.ill = 1'b0; d.alu = ALU_ADD; end
                else if (f3 == 3'b110) begin d.ill = 1'b0; d.alu = ALU_OR; end
                else if (f3 == 3'b111) begin d.ill = 1'b0; d.alu = ALU_AND; end
                d.src = 1'b1;
                d.rw  = 1'b1;
                d.rd  = ins[11:7];
                d.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0000011: begin
                d.ill = (f3 != 3'b010);
                d.alu = ALU_ADD;
                d.src = 1'b1;
                d.rw  = 1'b1;
                d.rd  = ins[11:7];
                d.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                d.ill = (f3 != 3'b010);
                d.alu = ALU_ADD;
                d.src = 1'b1;
                d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                d.ill = (f3 != 3'b000);
                d.alu = ALU_SUB;
                d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            default: d.ill = 1'b1;
        endcase
        if (d.ill) begin
            d     = '0;
            d.ill = 1'b1;
        end else begin
            d.rs1 = ins[19:15];
            d.rs2 = ins[24:20];
        end
        return d;
    endfunction

    assign in_ready  = rdy_en_q && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign dec_d     = decode(Instr);
    assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

    assign ALUControl = head.alu;
    assign ALUSrc     = head.src;
    assign Imm        = head.imm;
    assign Rd         = head.rd;
    assign Rs1        = head.rs1;
    assign Rs2        = head.rs2;
    assign RegWrite   = head.rw;
    assign Illegal    = head.ill;

    // Next-state for pointers and occupancy; simultaneous push and pop cancel in the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Queue control state; reset drops every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Entry storage; contents are only visible while counted, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_d;
    end

`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [7:0] ill_cnt_q;
    assign IllegalCount = ill_cnt_q;

    // Counts illegal words at acceptance time, sticking at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_q <= '0;
        end else if (push && dec_d.ill && ill_cnt_q != 8'hFF) begin
            ill_cnt_q <= ill_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed vector table, queue corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_alu_decoder;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ALUControl;
    logic        ALUSrc;
    logic [31:0] Imm;
    logic [4:0]  Rd, Rs1, Rs2;
    logic        RegWrite;
    logic        Illegal;
`ifdef ALU_DEC_ILLEGAL_CNT_EN
    logic [7:0]  IllegalCount;
`endif

    alu_decoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Instr(Instr), .out_valid(out_valid), .out_ready(out_ready),
        .ALUControl(ALUControl), .ALUSrc(ALUSrc), .Imm(Imm), .Rd(Rd),
        .Rs1(Rs1), .Rs2(Rs2), .RegWrite(RegWrite), .Illegal(Illegal)
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        , .IllegalCount(IllegalCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rw;
        logic        ill;
    } pay_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        pay_t        exp;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [11];
    pay_t q [$];

    function automatic pay_t observe();
        pay_t p;
        p = '{alu: ALUControl, src: ALUSrc, imm: Imm, rd: Rd, rs1: Rs1,
              rs2: Rs2, rw: RegWrite, ill: Illegal};
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode derived from the instruction-format rules with integer arithmetic.
    function automatic pay_t ref_decode(input logic [31:0] ins);
        pay_t p;
        int op, f3, f7, rd, rs1, rs2, imm_i, imm_s, imm_b, alu;
        bit legal, is_r, is_i, is_ld, is_st, is_br;
        p   = '0;
        op  = int'(ins & 32'h7F);
        f3  = int'((ins >> 12) & 32'h7);
        f7  = int'(ins >> 25);
        rd  = int'((ins >> 7) & 32'h1F);
        rs1 = int'((ins >> 15) & 32'h1F);
        rs2 = int'((ins >> 20) & 32'h1F);
        imm_i = int'($signed(ins) >>> 20);
        imm_s = int'($signed(ins) >>> 25) * 32 + rd;
        imm_b = (ins[31] ? -4096 : 0) + (ins[7] ? 2048 : 0)
              + int'((ins >> 25) & 32'h3F) * 32 + int'((ins >> 8) & 32'hF) * 2;
        alu = (f3 == 0) ? 2 : (f3 == 6) ? 1 : 0;
        is_r  = (op == 51) && ((f7 == 0 && (f3 == 0 || f3 == 6 || f3 == 7)) || (f7 == 32 && f3 == 0));
        is_i  = (op == 19) && (f3 == 0 || f3 == 6 || f3 == 7);
        is_ld = (op == 3)  && (f3 == 2);
        is_st = (op == 35) && (f3 == 2);
        is_br = (op == 99) && (f3 == 0);
        legal = is_r || is_i || is_ld || is_st || is_br;
        if (!legal) begin
            p.ill = 1'b1;
            return p;
        end
        p.rs1 = 5'(rs1);
        p.rs2 = 5'(rs2);
        if (is_r) begin
            p.alu = (f7 == 32) ? 4'd6 : 4'(alu);
            p.rd = 5'(rd); p.rw = 1'b1;
        end else if (is_i) begin
            p.alu = 4'(alu); p.src = 1'b1; p.imm = 32'(imm_i);
            p.rd = 5'(rd); p.rw = 1'b1;
        end else if (is_ld) begin
            p.alu = 4'd2; p.src = 1'b1; p.imm = 32'(imm_i);
            p.rd = 5'(rd); p.rw = 1'b1;
        end else if (is_st) begin
            p.alu = 4'd2; p.src = 1'b1; p.imm = 32'(imm_s);
        end else begin
            p.alu = 4'd6; p.imm = 32'(imm_b);
        end
        return p;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int r;
        logic [6:0] ops [5];
        logic [2:0] f3s [4];
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
        ins = $urandom;
        r = int'($urandom_range(0, 9));
        if (r < 8) begin
            ins[6:0] = ops[r % 5];
            if ($urandom_range(0, 3) != 0) ins[14:12] = f3s[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        end
        return ins;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({name, "_payload"}, 64'(observe()), 64'd0);
    endtask

    initial begin
        pay_t exp_p;
        bit   rdy_m, pop_m, acc_m;

        tbl[0]  = '{"add",   32'h002081B3, '{4'h2, 1'b0, 32'h0,        5'd3, 5'd1, 5'd2,  1'b1, 1'b0}};
        tbl[1]  = '{"sub",   32'h407302B3, '{4'h6, 1'b0, 32'h0,        5'd5, 5'd6, 5'd7,  1'b1, 1'b0}};
        tbl[2]  = '{"addi",  32'hFFF00093, '{4'h2, 1'b1, 32'hFFFFFFFF, 5'd1, 5'd0, 5'd31, 1'b1, 1'b0}};
        tbl[3]  = '{"beq",   32'h00208463, '{4'h6, 1'b0, 32'h8,        5'd0, 5'd1, 5'd2,  1'b0, 1'b0}};
        tbl[4]  = '{"zero",  32'h00000000, '{4'h0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  1'b0, 1'b1}};
        tbl[5]  = '{"or",    32'h0020E1B3, '{4'h1, 1'b0, 32'h0,        5'd3, 5'd1, 5'd2,  1'b1, 1'b0}};
        tbl[6]  = '{"and",   32'h0020F1B3, '{4'h0, 1'b0, 32'h0,        5'd3, 5'd1, 5'd2,  1'b1, 1'b0}};
        tbl[7]  = '{"lw",    32'hFFC12283, '{4'h2, 1'b1, 32'hFFFFFFFC, 5'd5, 5'd2, 5'd28, 1'b1, 1'b0}};
        tbl[8]  = '{"sw",    32'h00612423, '{4'h2, 1'b1, 32'h8,        5'd0, 5'd2, 5'd6,  1'b0, 1'b0}};
        tbl[9]  = '{"badf7", 32'h4020E1B3, '{4'h0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  1'b0, 1'b1}};
        tbl[10] = '{"slli",  32'h00109093, '{4'h0, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  1'b0, 1'b1}};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; Instr = 32'h0;
        #3;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk_empty("rst");
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        chk("rst_ill_cnt", 64'(IllegalCount), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk_empty("post_rst");

        // Directed vector table, one instruction at a time
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1; Instr = tbl[i].ins; out_ready = 1'b1;
            step();
            in_valid = 1'b0; Instr = $urandom;
            chk({tbl[i].name, "_valid"}, 64'(out_valid), 64'd1);
            chk(tbl[i].name, 64'(observe()), 64'(tbl[i].exp));
            step();
            chk_empty({tbl[i].name, "_drained"});
        end

        // Three back-to-back pushes into a full queue with the consumer stalled
        out_ready = 1'b0; in_valid = 1'b1;
        Instr = tbl[0].ins; step();
        Instr = tbl[1].ins; step();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        Instr = tbl[2].ins; step();
        chk("held_in_ready", 64'(in_ready), 64'd0);
        chk("held_head", 64'(observe()), 64'(tbl[0].exp));
        out_ready = 1'b1; step();
        chk("pop1_head", 64'(observe()), 64'(tbl[1].exp));
        chk("pop1_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("third_head", 64'(observe()), 64'(tbl[2].exp));
        chk("third_valid", 64'(out_valid), 64'd1);
        step();
        chk_empty("b2b_drained");

        // Randomized traffic against the queue model
        q.delete();
        for (int c = 0; c < 600; c++) begin
            rdy_m = (q.size() < DEPTH);
            chk("rnd_in_ready", 64'(in_ready), 64'(rdy_m));
            chk("rnd_out_valid", 64'(out_valid), 64'(q.size() != 0));
            exp_p = (q.size() != 0) ? q[0] : '0;
            chk("rnd_payload", 64'(observe()), 64'(exp_p));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 1) != 0);
            Instr     = rand_instr();
            @(posedge clk);
            acc_m = in_valid && rdy_m;
            pop_m = (q.size() != 0) && out_ready;
            if (pop_m) void'(q.pop_front());
            if (acc_m) q.push_back(ref_decode(Instr));
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        chk_empty("rnd_drained");

        // Asynchronous reset with two entries queued
        out_ready = 1'b0; in_valid = 1'b1;
        Instr = tbl[0].ins; step();
        Instr = tbl[4].ins; step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk_empty("mid_rst");
`ifdef ALU_DEC_ILLEGAL_CNT_EN
        chk("mid_rst_ill_cnt", 64'(IllegalCount), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk_empty("rel");
        out_ready = 1'b1; step();
        chk_empty("rel_no_stale");
        in_valid = 1'b1; Instr = tbl[3].ins; step();
        in_valid = 1'b0;
        chk("rel_fresh", 64'(observe()), 64'(tbl[3].exp));
        step();
        chk_empty("rel_drained");

`ifdef ALU_DEC_ILLEGAL_CNT_EN
        // Illegal counter: counts on accept and saturates at 255
        out_ready = 1'b0; in_valid = 1'b1; Instr = 32'h0;
        step(); step(); step();
        chk("ill_cnt_accept_only", 64'(IllegalCount), 64'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 298; k++) step();
        chk("ill_cnt_sat", 64'(IllegalCount), 64'd255);
        in_valid = 1'b0;
        step(); step();
        chk("ill_cnt_hold", 64'(IllegalCount), 64'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
